// File: rtl/ne16_package.sv
// Shared NE16 typedefs for the accumulator SCM march-test controller.
package ne16_package;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WAIT,
      ST_CMP,
      ST_WR0,
      ST_DONE
   } ne16_acc_bist_state_t;

   typedef enum logic [1:0] {
      ELEM_M0,
      ELEM_M1,
      ELEM_M2,
      ELEM_M3
   } ne16_acc_bist_elem_t;

   // M2 and M3 walk the address space downwards.
   function automatic logic elem_descending(input ne16_acc_bist_elem_t elem);
      return (elem == ELEM_M2) || (elem == ELEM_M3);
   endfunction

endpackage

// File: rtl/ne16_accumulator_bist_ctrl.sv
// March C- subset BIST controller for the NE16 accumulator SCM test wrapper.
// Every output is registered from the next-state view, so a_t_o/csn/wen/d always match state_q.
module ne16_accumulator_bist_ctrl
   import ne16_package::*;
#(
   parameter int ADDR_WIDTH   = 5,
   parameter int DATA_WIDTH   = 32,
   parameter int NUM_WORDS    = 2**ADDR_WIDTH,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic [DATA_WIDTH-1:0] pattern_i,
   output logic                  bist_o,
   output logic                  csn_t_o,
   output logic                  wen_t_o,
   output logic [ADDR_WIDTH-1:0] a_t_o,
   output logic [DATA_WIDTH-1:0] d_t_o,
   input  logic [DATA_WIDTH-1:0] q_t_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  pass_o,
   output logic                  fail_o,
   output logic [ADDR_WIDTH-1:0] fail_addr_o,
   output logic [DATA_WIDTH-1:0] fail_syndrome_o,
   output logic [1:0]            fail_element_o
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(NUM_WORDS - 1);
   localparam int WCW = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;
   localparam logic [WCW-1:0] WAIT_LAST = WCW'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

   function automatic logic [DATA_WIDTH-1:0] exp_word(input ne16_acc_bist_elem_t elem,
                                                      input logic [DATA_WIDTH-1:0] pat);
      return (elem == ELEM_M2) ? ~pat : pat;
   endfunction

   ne16_acc_bist_state_t  state_q, state_d;
   ne16_acc_bist_elem_t   elem_q, elem_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [WCW-1:0]        wait_cnt_q, wait_cnt_d;
   logic [DATA_WIDTH-1:0] pattern_q, pattern_d;
   logic                  bist_q, bist_d, csn_q, csn_d, wen_q, wen_d;
   logic [DATA_WIDTH-1:0] d_q, d_d;
   logic                  busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic                  fail_q, fail_d;
   logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
   logic [DATA_WIDTH-1:0] fail_syn_q, fail_syn_d;
   logic [1:0]            fail_elem_q, fail_elem_d;
   logic [DATA_WIDTH-1:0] expected;
   logic                  start_ok;
   logic                  cmp_write;

   always_comb begin
      state_d     = state_q;
      elem_d      = elem_q;
      addr_d      = addr_q;
      wait_cnt_d  = wait_cnt_q;
      pattern_d   = pattern_q;
      fail_d      = fail_q;
      fail_addr_d = fail_addr_q;
      fail_syn_d  = fail_syn_q;
      fail_elem_d = fail_elem_q;
      expected    = exp_word(elem_q, pattern_q);
      start_ok    = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start_i && !abort_i;

      unique case (state_q)
         ST_WR0: begin
            if (addr_q == ADDR_LAST) begin
               state_d = ST_RD;
               elem_d  = ELEM_M1;
               addr_d  = '0;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         ST_RD: begin
            wait_cnt_d = '0;
            state_d    = (READ_LATENCY == 1) ? ST_CMP : ST_WAIT;
         end
         ST_WAIT: begin
            if (wait_cnt_q == WAIT_LAST) state_d = ST_CMP;
            else                         wait_cnt_d = wait_cnt_q + 1'b1;
         end
         ST_CMP: begin
            // Only the first mismatch is captured; later ones just keep fail set.
            if (q_t_i != expected) begin
               fail_d = 1'b1;
               if (!fail_q) begin
                  fail_addr_d = addr_q;
                  fail_syn_d  = q_t_i ^ expected;
                  fail_elem_d = elem_q;
               end
            end
            state_d = ST_RD;
            if (elem_descending(elem_q)) begin
               if (addr_q != '0) begin
                  addr_d = addr_q - 1'b1;
               end else if (elem_q == ELEM_M3) begin
                  state_d = ST_DONE;
               end else begin
                  elem_d = ELEM_M3;
                  addr_d = ADDR_LAST;
               end
            end else begin
               if (addr_q != ADDR_LAST) begin
                  addr_d = addr_q + 1'b1;
               end else begin
                  elem_d = ELEM_M2;
                  addr_d = ADDR_LAST;
               end
            end
         end
         default: ;
      endcase

      if (start_ok) begin
         state_d     = ST_WR0;
         elem_d      = ELEM_M0;
         addr_d      = '0;
         pattern_d   = pattern_i;
         fail_d      = 1'b0;
         fail_addr_d = '0;
         fail_syn_d  = '0;
         fail_elem_d = '0;
      end
      if (abort_i && (state_q != ST_IDLE)) state_d = ST_IDLE;

      // Output registers are loaded with the values belonging to state_d.
      cmp_write = (state_d == ST_CMP) && (elem_d != ELEM_M3);
      busy_d    = (state_d != ST_IDLE) && (state_d != ST_DONE);
      bist_d    = busy_d;
      csn_d     = !((state_d == ST_WR0) || (state_d == ST_RD) || cmp_write);
      wen_d     = !((state_d == ST_WR0) || cmp_write);
      d_d       = d_q;
      if (state_d == ST_WR0) d_d = pattern_d;
      else if (cmp_write)    d_d = ~exp_word(elem_d, pattern_d);
      done_d    = (state_d == ST_DONE);
      pass_d    = done_d && !fail_d;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         elem_q      <= ELEM_M0;
         addr_q      <= '0;
         wait_cnt_q  <= '0;
         pattern_q   <= '0;
         bist_q      <= 1'b0;
         csn_q       <= 1'b1;
         wen_q       <= 1'b1;
         d_q         <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_syn_q  <= '0;
         fail_elem_q <= '0;
      end else begin
         state_q     <= state_d;
         elem_q      <= elem_d;
         addr_q      <= addr_d;
         wait_cnt_q  <= wait_cnt_d;
         pattern_q   <= pattern_d;
         bist_q      <= bist_d;
         csn_q       <= csn_d;
         wen_q       <= wen_d;
         d_q         <= d_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
         fail_addr_q <= fail_addr_d;
         fail_syn_q  <= fail_syn_d;
         fail_elem_q <= fail_elem_d;
      end
   end

   assign bist_o          = bist_q;
   assign csn_t_o         = csn_q;
   assign wen_t_o         = wen_q;
   assign a_t_o           = addr_q;
   assign d_t_o           = d_q;
   assign busy_o          = busy_q;
   assign done_o          = done_q;
   assign pass_o          = pass_q;
   assign fail_o          = fail_q;
   assign fail_addr_o     = fail_addr_q;
   assign fail_syndrome_o = fail_syn_q;
   assign fail_element_o  = fail_elem_q;

endmodule

// File: tb/tb_ne16_accumulator_bist_ctrl.sv
// Directed bench: a 32-word L=1 controller and a 5-word L=3 controller, each driving an SCM model
// with per-address stuck-at masks.
module tb_ne16_accumulator_bist_ctrl;

   localparam logic [31:0] PAT_A = 32'hA5A5_5A5A;
   localparam logic [31:0] PAT_B = 32'h0F0F_3C3C;

   logic        clk;
   logic        rst_n;

   logic        startA, abortA;
   logic [31:0] patternA;
   logic        bistA, csnA, wenA, busyA, doneA, passA, failA;
   logic [4:0]  aA, failAddrA;
   logic [31:0] dA, qA, failSynA;
   logic [1:0]  failElemA;

   logic        startB, abortB;
   logic [31:0] patternB;
   logic        bistB, csnB, wenB, busyB, doneB, passB, failB;
   logic [2:0]  aB, failAddrB;
   logic [31:0] dB, q1B, q2B, q3B, failSynB;
   logic [1:0]  failElemB;

   logic [31:0] memA [32];
   logic [31:0] sa1A [32];
   logic [31:0] sa0A [32];
   logic [31:0] memB [8];

   int compareCount = 0;
   int errCount     = 0;
   int readsA       = 0;
   int readsB       = 0;
   int snap;
   int total;

   ne16_accumulator_bist_ctrl dutA (
      .clk_i(clk), .rst_ni(rst_n), .start_i(startA), .abort_i(abortA), .pattern_i(patternA),
      .bist_o(bistA), .csn_t_o(csnA), .wen_t_o(wenA), .a_t_o(aA), .d_t_o(dA), .q_t_i(qA),
      .busy_o(busyA), .done_o(doneA), .pass_o(passA), .fail_o(failA),
      .fail_addr_o(failAddrA), .fail_syndrome_o(failSynA), .fail_element_o(failElemA)
   );

   ne16_accumulator_bist_ctrl #(
      .ADDR_WIDTH(3), .DATA_WIDTH(32), .NUM_WORDS(5), .READ_LATENCY(3)
   ) dutB (
      .clk_i(clk), .rst_ni(rst_n), .start_i(startB), .abort_i(abortB), .pattern_i(patternB),
      .bist_o(bistB), .csn_t_o(csnB), .wen_t_o(wenB), .a_t_o(aB), .d_t_o(dB), .q_t_i(q3B),
      .busy_o(busyB), .done_o(doneB), .pass_o(passB), .fail_o(failB),
      .fail_addr_o(failAddrB), .fail_syndrome_o(failSynB), .fail_element_o(failElemB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SCM model A: one-cycle read latency, stuck-at faults applied on the read path.
   always @(posedge clk) begin
      if (!csnA) begin
         if (!wenA) memA[aA] <= dA;
         else begin
            qA     <= (memA[aA] | sa1A[aA]) & ~sa0A[aA];
            readsA <= readsA + 1;
         end
      end
   end

   // SCM model B: three-stage read pipeline.
   always @(posedge clk) begin
      q2B <= q1B;
      q3B <= q2B;
      if (!csnB) begin
         if (!wenB) memB[aB] <= dB;
         else begin
            q1B    <= memB[aB];
            readsB <= readsB + 1;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compareCount++;
      assert (observed === expected)
      else begin
         errCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drives a one-cycle start pulse; returns at the negedge of the first active cycle.
   task automatic applyStimulus(input logic selB, input logic [31:0] pat);
      if (selB) begin patternB = pat; startB = 1'b1; end
      else      begin patternA = pat; startA = 1'b1; end
      @(negedge clk);
      startA = 1'b0;
      startB = 1'b0;
   endtask

   task automatic waitDone(input logic selB, input int startCount, output int count);
      count = startCount;
      for (int i = 0; i < 3000 && (selB ? busyB : busyA); i++) begin
         @(negedge clk);
         if (selB ? busyB : busyA) count++;
      end
      checkOutput("busy_timeout", {63'd0, selB ? busyB : busyA}, 64'd0);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         sa1A[i] = '0;
         sa0A[i] = '0;
      end
      rst_n = 1'b0; startA = 1'b0; abortA = 1'b0; patternA = '0;
      startB = 1'b0; abortB = 1'b0; patternB = '0;
      repeat (2) @(negedge clk);

      // Reset values
      checkOutput("rst_ctrl", {bistA, csnA, wenA, busyA, doneA, passA, failA}, 64'b0110000);
      checkOutput("rst_a_d", {aA, dA}, 64'd0);
      checkOutput("rst_capture", {failAddrA, failSynA, failElemA}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Clean run
      snap = readsA;
      applyStimulus(1'b0, PAT_A);
      checkOutput("first_write", {bistA, busyA, csnA, wenA, aA, dA}, {2'b11, 2'b00, 5'd0, PAT_A});
      waitDone(1'b0, 1, total);
      checkOutput("clean_cycles", total, 224);
      checkOutput("clean_status", {doneA, passA, failA, busyA, bistA}, 64'b11000);
      checkOutput("clean_reads", readsA - snap, 96);
      repeat (3) @(negedge clk);
      checkOutput("done_hold", {doneA, passA, csnA, wenA}, 64'b1111);

      // Stuck-at-1 bit 3 at address 7: M1 passes, M2 read of ~P fails
      sa1A[7] = 32'h8;
      applyStimulus(1'b0, PAT_A);
      checkOutput("rerun_clears", {doneA, passA, busyA}, 64'b001);
      waitDone(1'b0, 1, total);
      checkOutput("sa1_cycles", total, 224);
      checkOutput("sa1_status", {doneA, passA, failA}, 64'b101);
      checkOutput("sa1_addr", failAddrA, 7);
      checkOutput("sa1_elem", failElemA, 2);
      checkOutput("sa1_syndrome", failSynA, 32'h8);

      // Stuck-at-0 bit 1 at addresses 4 and 20: first capture is 4 in M1
      sa1A[7] = '0;
      sa0A[4] = 32'h2;
      sa0A[20] = 32'h2;
      applyStimulus(1'b0, PAT_A);
      checkOutput("start_clears_capture", {failA, failAddrA, failSynA, failElemA}, 64'd0);
      waitDone(1'b0, 1, total);
      checkOutput("two_fault_status", {doneA, passA, failA}, 64'b101);
      checkOutput("two_fault_addr", failAddrA, 4);
      checkOutput("two_fault_elem", failElemA, 1);
      checkOutput("two_fault_syndrome", failSynA, 32'h2);

      // Start while busy is ignored, then abort at cycle 50
      applyStimulus(1'b0, PAT_A);
      repeat (10) @(negedge clk);
      checkOutput("wr0_addr10", aA, 10);
      patternA = 32'hFFFF_0000;
      startA = 1'b1;
      @(negedge clk);
      startA = 1'b0;
      patternA = PAT_A;
      checkOutput("busy_start_ignored", {busyA, aA, dA}, {1'b1, 5'd11, PAT_A});
      repeat (38) @(negedge clk);
      abortA = 1'b1;
      @(negedge clk);
      abortA = 1'b0;
      checkOutput("abort_ctrl", {bistA, busyA, doneA, passA, csnA, wenA}, 64'b000011);
      checkOutput("abort_keeps_capture", {failA, failAddrA, failElemA}, {1'b1, 5'd4, 2'd1});

      // Fresh start clears captures, then asynchronous reset in the middle of M2
      sa0A[4] = '0;
      sa0A[20] = '0;
      applyStimulus(1'b0, PAT_A);
      checkOutput("fresh_clear", {failA, failAddrA, failSynA, failElemA}, 64'd0);
      repeat (109) @(negedge clk);
      checkOutput("m2_addr", {aA, csnA, wenA}, {5'd25, 2'b00});
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_rst", {bistA, csnA, wenA, busyA, aA, dA}, {4'b0110, 5'd0, 32'd0});
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(1'b0, PAT_A);
      waitDone(1'b0, 1, total);
      checkOutput("post_rst_cycles", total, 224);
      checkOutput("post_rst_status", {doneA, passA, failA}, 64'b110);

      // Five words, read latency 3: 4-cycle spacing in M1..M3, 65 active cycles
      snap = readsB;
      applyStimulus(1'b1, PAT_B);
      checkOutput("b_first_write", {csnB, wenB, aB, dB}, {2'b00, 3'd0, PAT_B});
      repeat (5) @(negedge clk);
      checkOutput("b_rd0", {csnB, wenB, aB}, {2'b01, 3'd0});
      @(negedge clk);
      checkOutput("b_wait", {busyB, csnB, wenB}, 64'b111);
      repeat (2) @(negedge clk);
      checkOutput("b_cmp_write", {csnB, wenB, aB, dB}, {2'b00, 3'd0, ~PAT_B});
      @(negedge clk);
      checkOutput("b_rd1", {csnB, wenB, aB}, {2'b01, 3'd1});
      waitDone(1'b1, 10, total);
      checkOutput("b_cycles", total, 65);
      checkOutput("b_status", {doneB, passB, failB}, 64'b110);
      checkOutput("b_reads", readsB - snap, 15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errCount);
      $finish;
   end

endmodule
